boot_rom_arbiter: RTL
=====================

// Module: boot_rom_arbiter
// PURPOSE
//  Shares the single combinational boot ROM port between NR_PORTS requesters (e.g. fetch, load/store, debug).
//  Round-robin arbitration with a req/gnt/rvalid handshake; one access granted per cycle, response one cycle later.
//  Drives the ROM address, registers the ROM data and flags out-of-range accesses. Sits between core ports and the ROM.
// PARAMETERS
//  NR_PORTS  2             number of requesters (1..8)
//  ROM_BASE  64'h1000      first byte address decoded as ROM
//  ROM_SIZE  64'h1000      ROM window size in bytes (multiple of 8)
// PORTS
//  clk_i       in   1              clock, rising edge
//  rst_ni      in   1              asynchronous reset, active low
//  req_i       in   NR_PORTS       per-port request; held with addr_i stable until gnt_o
//  addr_i      in   NR_PORTS x 64  per-port byte address
//  gnt_o       out  NR_PORTS       per-port grant, one-hot or zero, combinational from req_i and rr pointer
//  rvalid_o    out  NR_PORTS       per-port response valid, one cycle after gnt_o
//  rdata_o     out  NR_PORTS x 64  per-port read data, valid with rvalid_o
//  err_o       out  NR_PORTS       per-port decode error, valid with rvalid_o
//  rom_addr_o  out  64             address to ROM, doubleword aligned (addr & ~64'h7)
//  rom_data_i  in   64             ROM read data, combinational from rom_addr_o
// BEHAVIOUR
//  Reset: rr pointer=0, rvalid_o=0, err_o=0, rdata_o=0, resp port=0; gnt_o follows req_i immediately after reset release.
//  Arbitration (cycle N): scan ports starting at rr pointer, wrap at NR_PORTS-1 -> 0; first asserted req_i gets gnt_o.
//  At most one gnt_o per cycle; no req_i -> gnt_o=0, rom_addr_o=0, rr pointer unchanged.
//  On grant to port k: rr pointer <= (k+1) mod NR_PORTS at clock edge; winner becomes lowest priority.
//  rom_addr_o = {addr_i[k][63:3],3'b000} of the granted port in cycle N; low 3 address bits ignored.
//  Decode: hit iff ROM_BASE <= addr < ROM_BASE+ROM_SIZE (64-bit unsigned compare, no overflow wrap).
//  Cycle N+1: rvalid_o[k]=1 for exactly one cycle; hit -> rdata_o[k]=rom_data_i sampled at edge N, err_o[k]=0;
//    miss -> rdata_o[k]=0, err_o[k]=1, rom_addr_o forced to 0 in cycle N.
//  Ports not responding: rvalid_o=0, err_o=0, rdata_o holds last value (no protocol meaning).
//  Throughput: back-to-back grants allowed, one per cycle; a port may be granted in N and N+1 (rvalid in N+1, N+2).
//  Grant and response of different ports may coincide in one cycle; they are independent.
//  Latency fixed at 1; no backpressure on response: requester must accept rvalid_o when it arrives.
//  Withdrawn req_i before gnt_o is tolerated (no grant, no response); changing addr_i while req_i high is illegal (assertion).
//  rom_data_i containing X for an aligned in-window word is passed through unchanged (not masked).
//  Reset asserted mid-operation: pending response dropped, rvalid_o=0 immediately (async), rr pointer -> 0.
//  No internal FSM beyond rr pointer and 1-deep response register (valid, port id, err, data).
// TESTING
//  1) Single port 0, req addr 64'h1000 -> gnt_o[0] same cycle, rom_addr_o=64'h1000, next cycle rvalid_o[0]=1,
//     rdata_o[0]=rom_data_i, err_o[0]=0.
//  2) Unaligned addr 64'h100C from port 1 -> rom_addr_o=64'h1008; response on port 1 only, data of doubleword 64'h1008.
//  3) Both ports req every cycle from reset -> grants 0,1,0,1...; each port gets rvalid one cycle after its grant; never two gnts.
//  4) Out-of-range 64'h0FF8 and 64'h2000 -> gnt same cycle, rom_addr_o=0, next cycle err_o=1, rdata_o=0, rvalid_o=1.
//  5) Port 0 granted, rst_ni low before response edge -> no rvalid_o; after release rr pointer=0, port 0 wins a tie.
//  6) Port 1 alone for 3 cycles then port 0 joins while rr=0 -> port 0 granted next, then port 1; boundary 64'h1FF8 hits, err_o=0.

Source files
------------

// File: rtl/boot_rom_arbiter.sv
// Round-robin share of one combinational boot ROM port; grant is combinational, response registered 1 cycle later.
// No backpressure: requesters hold req/addr until gnt and must accept rvalid the cycle it arrives.
module boot_rom_arbiter #(
    parameter int unsigned NR_PORTS = 2,
    parameter logic [63:0] ROM_BASE = 64'h1000,
    parameter logic [63:0] ROM_SIZE = 64'h1000
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NR_PORTS-1:0]       req_i,
    input  logic [NR_PORTS-1:0][63:0] addr_i,
    output logic [NR_PORTS-1:0]       gnt_o,
    output logic [NR_PORTS-1:0]       rvalid_o,
    output logic [NR_PORTS-1:0][63:0] rdata_o,
    output logic [NR_PORTS-1:0]       err_o,
    output logic [63:0]               rom_addr_o,
    input  logic [63:0]               rom_data_i
);
    localparam int unsigned PTR_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

    logic [PTR_W-1:0]          rr_q, rr_d;
    logic                      rsp_vld_q, rsp_vld_d;
    logic [PTR_W-1:0]          rsp_port_q, rsp_port_d;
    logic                      rsp_err_q, rsp_err_d;
    logic [NR_PORTS-1:0][63:0] rdata_q, rdata_d;

    logic             any_req;
    logic [PTR_W-1:0] win;
    logic [63:0]      win_addr;
    logic             hit;

    // Scan from the rr pointer with wrap; first requester found wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        any_req = 1'b0;
        win     = '0;
        idx     = '0;
        for (int i = 0; i < NR_PORTS; i++) begin
            idx = PTR_W'((int'(rr_q) + i) % NR_PORTS);
            if (!any_req && req_i[idx]) begin
                any_req = 1'b1;
                win     = idx;
            end
        end
    end

    // 65-bit compare so a window ending at the top of the address space cannot wrap.
    assign win_addr = addr_i[win];
    assign hit      = ({1'b0, win_addr} >= {1'b0, ROM_BASE}) &&
                      ({1'b0, win_addr} < ({1'b0, ROM_BASE} + {1'b0, ROM_SIZE}));

    always_comb begin
        gnt_o = '0;
        if (any_req) begin
            gnt_o[win] = 1'b1;
        end
    end

    assign rom_addr_o = (any_req && hit) ? {win_addr[63:3], 3'b000} : 64'h0;

    always_comb begin
        rr_d       = rr_q;
        rsp_vld_d  = any_req;
        rsp_port_d = rsp_port_q;
        rsp_err_d  = rsp_err_q;
        rdata_d    = rdata_q;
        if (any_req) begin
            rr_d          = PTR_W'((int'(win) + 1) % NR_PORTS);
            rsp_port_d    = win;
            rsp_err_d     = !hit;
            rdata_d[win]  = hit ? rom_data_i : 64'h0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_port_q <= '0;
            rsp_err_q  <= 1'b0;
            rdata_q    <= '0;
        end else begin
            rr_q       <= rr_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_port_q <= rsp_port_d;
            rsp_err_q  <= rsp_err_d;
            rdata_q    <= rdata_d;
        end
    end

    // Non-responding ports keep their last data; only valid/err are qualified per port.
    always_comb begin
        rvalid_o = '0;
        err_o    = '0;
        for (int k = 0; k < NR_PORTS; k++) begin
            if (rsp_vld_q && (rsp_port_q == PTR_W'(k))) begin
                rvalid_o[k] = 1'b1;
                err_o[k]    = rsp_err_q;
            end
        end
    end

    assign rdata_o = rdata_q;

    for (genvar k = 0; k < NR_PORTS; k++) begin : g_addr_stable
        a_addr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (req_i[k] && !gnt_o[k]) |=> (!req_i[k] || $stable(addr_i[k])));
    end

endmodule
